// File: rtl/alu_serial_responder_if.sv
// Serial link bundle between the ALU BFM (master) and the responder (slave).
interface alu_serial_responder_if;
  logic sin;
  logic sout;
  logic busy;

  modport master (output sin, input sout, input busy);
  modport slave  (input sin, output sout, output busy);
endinterface

// File: rtl/alu_serial_responder.sv
// Far-end responder for the ALU serial link: deserializes a request frame,
// validates it, computes the ALU result and serializes a result or error frame.
module alu_serial_responder (
  input  logic                 clk,
  input  logic                 rst,
  alu_serial_responder_if.slave bus
);

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_BITS = 2'd1;
  localparam logic [1:0] RX_EVAL = 2'd2;
  localparam logic [1:0] RX_RESP = 2'd3;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_DATA = 2'd1;
  localparam logic [1:0] TX_CTL  = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // MSB-first CRC, x^4+x+1, init 0
  function automatic logic [3:0] crc4_calc(input logic [67:0] din);
    logic [67:0] d;
    logic [3:0]  c;
    logic        fb;
    d = din;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ d[67];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      d  = d << 1;
    end
    return c;
  endfunction

  // MSB-first CRC, x^3+x+1, init 0
  function automatic logic [2:0] crc3_calc(input logic [36:0] din);
    logic [36:0] d;
    logic [2:0]  c;
    logic        fb;
    d = din;
    c = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb = c[2] ^ d[36];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
      d  = d << 1;
    end
    return c;
  endfunction

  logic [1:0]  rx_state;
  logic [3:0]  rx_bit;
  logic [9:0]  rx_sr;
  logic [3:0]  data_cnt;
  logic        stop_err;
  logic [63:0] data_sr;

  logic [1:0]  tx_state;
  logic [3:0]  tx_bit;
  logic [1:0]  tx_pkt;
  logic [9:0]  tx_sr;
  logic [31:0] tx_data;
  logic [7:0]  tx_ctl;
  logic        sout_q;
  logic        busy_q;

  logic [31:0] op_b;
  logic [31:0] op_a;
  logic [2:0]  op;
  logic [3:0]  crc_rx;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] res;
  logic        carry;
  logic        ovf;
  logic        op_ok;
  logic [3:0]  flags;
  logic        crc_ok;
  logic        e_data;
  logic [2:0]  err_e;
  logic        err_any;
  logic [7:0]  err_byte;
  logic [7:0]  res_ctl;
  logic        ctl_done;

  assign bus.sout = sout_q;
  assign bus.busy = busy_q;

  // The ctl packet's stop bit is being sampled this cycle
  assign ctl_done = (rx_state == RX_BITS) && (rx_bit == 4'd9) && rx_sr[8];

  // In RX_EVAL rx_sr holds {type, payload[7:0], stop}
  always_comb begin
    op_b   = data_sr[63:32];
    op_a   = data_sr[31:0];
    op     = rx_sr[7:5];
    crc_rx = rx_sr[4:1];
    sum    = {1'b0, op_b} + {1'b0, op_a};
    diff   = {1'b0, op_b} - {1'b0, op_a};
    res    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    op_ok  = 1'b1;
    case (op)
      OP_AND: res = op_b & op_a;
      OP_OR:  res = op_b | op_a;
      OP_ADD: begin
        res   = sum[31:0];
        carry = sum[32];
        ovf   = (op_b[31] == op_a[31]) && (sum[31] != op_b[31]);
      end
      OP_SUB: begin
        res   = diff[31:0];
        carry = diff[32];
        ovf   = (op_b[31] != op_a[31]) && (diff[31] != op_b[31]);
      end
      default: op_ok = 1'b0;
    endcase
    flags   = {carry, ovf, (res == '0), res[31]};
    crc_ok  = (crc4_calc({op_b, op_a, 1'b1, op}) == crc_rx);
    e_data  = (data_cnt != 4'd8) || stop_err || !rx_sr[0];
    if (e_data)       err_e = 3'b100;
    else if (!crc_ok) err_e = 3'b010;
    else if (!op_ok)  err_e = 3'b001;
    else              err_e = 3'b000;
    err_any  = |err_e;
    err_byte = {1'b1, err_e, err_e, 1'b0};
    err_byte[0] = ^err_byte[7:1];
    res_ctl  = {1'b0, flags, crc3_calc({res, 1'b0, flags})};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_bit   <= '0;
      rx_sr    <= '0;
      data_cnt <= '0;
      stop_err <= 1'b0;
      data_sr  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!bus.sin) begin
            rx_state <= RX_BITS;
            rx_bit   <= '0;
          end
        end
        RX_BITS: begin
          rx_sr  <= {rx_sr[8:0], bus.sin};
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit == 4'd9) rx_state <= RX_EVAL;
        end
        RX_EVAL: begin
          if (rx_sr[9]) begin
            rx_state <= RX_RESP;
          end else begin
            data_sr <= {data_sr[55:0], rx_sr[8:1]};
            if (data_cnt != 4'd9) data_cnt <= data_cnt + 4'd1;
            if (!rx_sr[0]) stop_err <= 1'b1;
            rx_state <= RX_IDLE;
          end
        end
        RX_RESP: begin
          // sin stays ignored until the cycle after busy drops
          if (!busy_q) begin
            rx_state <= RX_IDLE;
            data_cnt <= '0;
            stop_err <= 1'b0;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_bit   <= '0;
      tx_pkt   <= '0;
      tx_sr    <= '0;
      tx_data  <= '0;
      tx_ctl   <= '0;
      sout_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (ctl_done) busy_q <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if ((rx_state == RX_EVAL) && rx_sr[9]) begin
            sout_q <= 1'b0;
            tx_bit <= '0;
            if (err_any) begin
              tx_state <= TX_CTL;
              tx_sr    <= {1'b1, err_byte, 1'b1};
            end else begin
              tx_state <= TX_DATA;
              tx_pkt   <= '0;
              tx_sr    <= {1'b0, res[31:24], 1'b1};
              tx_data  <= {res[23:0], 8'h00};
              tx_ctl   <= res_ctl;
            end
          end
        end
        TX_DATA, TX_CTL: begin
          if (tx_bit != 4'd10) begin
            sout_q <= tx_sr[9];
            tx_sr  <= {tx_sr[8:0], 1'b0};
            tx_bit <= tx_bit + 4'd1;
          end else if (tx_state == TX_CTL) begin
            tx_state <= TX_IDLE;
            sout_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            // stop bit just went out: next start bit follows with no idle gap
            sout_q <= 1'b0;
            tx_bit <= '0;
            if (tx_pkt == 2'd3) begin
              tx_state <= TX_CTL;
              tx_sr    <= {1'b1, tx_ctl, 1'b1};
            end else begin
              tx_pkt  <= tx_pkt + 2'd1;
              tx_sr   <= {1'b0, tx_data[31:24], 1'b1};
              tx_data <= {tx_data[23:0], 8'h00};
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Randomized bench for alu_serial_responder with a frame-level reference model
// predicting sout/busy for every cycle.
module tb_alu_serial_responder;

  logic clk;
  logic rst;
  alu_serial_responder_if bus();

  alu_serial_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expected {busy, sout} per cycle; absent entries mean idle (busy 0, sout 1)
  logic [1:0] exp_q [int];

  bit cur_bits[$];
  bit last_bits[$];
  int busy_cnt = 0;
  int last_len = 0;

  logic [31:0] m_c;
  logic [3:0]  m_fl;
  logic [7:0]  m_ctl;
  bit          m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC as the remainder of polynomial long division of msg * x^w by g
  function automatic logic [3:0] poly_rem(input logic [67:0] msg, input int len,
                                          input int w, input logic [4:0] g);
    logic [75:0] m;
    m = {8'b0, msg} << w;
    for (int i = len + w - 1; i >= w; i--)
      if (m[7'(i)]) m = m ^ ({71'b0, g} << (i - w));
    return m[3:0];
  endfunction

  function automatic void model(input logic [31:0] b, input logic [31:0] a,
                                input logic [2:0] op, input bit edata, input bit ecrc,
                                output logic [31:0] c, output logic [3:0] fl,
                                output logic [7:0] ctl, output bit is_err);
    logic [2:0]      e;
    bit              cy, ov, valid;
    longint unsigned us;
    longint          ss;
    c = 0; cy = 0; ov = 0; valid = 1;
    case (op)
      3'b000: c = b & a;
      3'b001: c = b | a;
      3'b100: begin
        us = 64'(b) + 64'(a);
        c  = us[31:0];
        cy = us > 64'hFFFF_FFFF;
        ss = longint'($signed(b)) + longint'($signed(a));
        ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'b101: begin
        c  = b - a;
        cy = b < a;
        ss = longint'($signed(b)) - longint'($signed(a));
        ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: valid = 0;
    endcase
    fl = {cy, ov, c == 0, c[31]};
    if (edata)       e = 3'b100;
    else if (ecrc)   e = 3'b010;
    else if (!valid) e = 3'b001;
    else             e = 3'b000;
    is_err = (e != 0);
    if (is_err) ctl = {1'b1, e, e, 1'($countones({1'b1, e, e}) % 2)};
    else        ctl = {1'b0, fl, poly_rem({31'b0, c, 1'b0, fl}, 37, 3, 5'b01011)[2:0]};
  endfunction

  // Compare and capture, away from the active edge
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    e = exp_q.exists(cyc) ? exp_q[cyc] : 2'b01;
    chk("sout_busy", {bus.busy, bus.sout}, e);
    if (bus.busy) begin
      cur_bits.push_back(bus.sout);
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      last_bits = cur_bits;
      last_len  = busy_cnt;
      cur_bits.delete();
      busy_cnt = 0;
    end
  end

  task automatic drive_bit(input bit v);
    @(negedge clk);
    bus.sin = v;
  endtask

  task automatic send_packet(input bit typ, input logic [7:0] payload, input bit stop);
    logic [7:0] p;
    p = payload;
    drive_bit(1'b0);
    drive_bit(typ);
    for (int j = 0; j < 8; j++) begin
      drive_bit(p[7]);
      p = p << 1;
    end
    drive_bit(stop);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input int ndata, input logic [3:0] crc_flip, input int bad_stop,
                            input bit toggle, input int abort_at);
    logic [63:0] ab;
    logic [3:0]  crc;
    logic [10:0] pk[$];
    logic [10:0] p;
    bit          q[$];
    bit          edata;
    int          c0, len;
    ab  = {b, a};
    crc = poly_rem({b, a, 1'b1, op}, 68, 4, 5'b10011) ^ crc_flip;
    for (int k = 0; k < ndata; k++) begin
      send_packet(1'b0, 8'(ab >> (56 - 8 * (k % 8))), (k == bad_stop) ? 1'b0 : 1'b1);
      repeat ($urandom_range(1, 3)) drive_bit(1'b1);
    end
    edata = (ndata != 8) || (bad_stop >= 0 && bad_stop < ndata);
    model(b, a, op, edata, crc_flip != 0, m_c, m_fl, m_ctl, m_err);
    if (!m_err)
      for (int j = 0; j < 4; j++) pk.push_back({1'b0, 1'b0, 8'(m_c >> (24 - 8 * j)), 1'b1});
    pk.push_back({1'b0, 1'b1, m_ctl, 1'b1});
    foreach (pk[i]) begin
      p = pk[i];
      for (int j = 0; j < 11; j++) begin
        q.push_back(p[10]);
        p = p << 1;
      end
    end
    send_packet(1'b1, {1'b0, op, crc}, 1'b1);
    c0 = cyc;
    exp_q[c0 + 1] = 2'b11;
    foreach (q[i]) exp_q[c0 + 2 + i] = {1'b1, q[i]};
    len = q.size();
    if (abort_at > 0) begin
      repeat (abort_at + 1) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("abort_sout", bus.sout, 1);
      chk("abort_busy", bus.busy, 0);
      exp_q.delete();
      bus.sin = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) drive_bit(1'b1);
    end else begin
      for (int i = 0; i < len + 4; i++)
        drive_bit((toggle && i < len - 1) ? 1'($urandom) : 1'b1);
      repeat (2) drive_bit(1'b1);
    end
  endtask

  function automatic logic [7:0] rsp_byte(input int k);
    logic [7:0] v;
    int         idx;
    v = 0;
    for (int j = 0; j < 8; j++) begin
      idx = 3 + 11 * k + j;
      v = {v[6:0], (idx < last_bits.size()) ? last_bits[idx] : 1'b0};
    end
    return v;
  endfunction

  task automatic chk_rsp(input string tag, input logic [31:0] c, input logic [3:0] fl);
    logic [7:0] ctl;
    ctl = rsp_byte(4);
    chk({tag, "_model_c"}, m_c, c);
    chk({tag, "_model_fl"}, m_fl, fl);
    chk({tag, "_len"}, last_len, 56);
    chk({tag, "_c"}, {rsp_byte(0), rsp_byte(1), rsp_byte(2), rsp_byte(3)}, c);
    chk({tag, "_fl"}, ctl[6:3], fl);
  endtask

  task automatic chk_err(input string tag, input logic [7:0] eb);
    chk({tag, "_model"}, m_ctl, eb);
    chk({tag, "_len"}, last_len, 12);
    chk({tag, "_byte"}, rsp_byte(0), eb);
  endtask

  initial begin
    logic [31:0] rb, ra;
    logic [2:0]  rop;
    int          nd, bs;
    logic [3:0]  cf;
    logic [2:0]  ops [8];
    ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b100, 3'b101, 3'b010, 3'b111};

    rst = 1'b1;
    bus.sin = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_sout", bus.sout, 1);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (3) drive_bit(1'b1);

    send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 8, 4'b0, -1, 0, 0);
    chk_rsp("add_small", 32'h0000_0008, 4'b0000);
    send_frame(32'h0000_0001, 32'h0000_0002, 3'b101, 8, 4'b0, -1, 0, 0);
    chk_rsp("sub_borrow", 32'hFFFF_FFFF, 4'b1001);
    send_frame(32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 8, 4'b0, -1, 0, 0);
    chk_rsp("add_ovf", 32'h8000_0000, 4'b0101);
    send_frame(32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 8, 4'b0, -1, 0, 0);
    chk_rsp("and_zero", 32'h0000_0000, 4'b0010);

    send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 7, 4'b0, -1, 0, 0);
    chk_err("short_frame", 8'hC9);
    send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 8, 4'b0100, -1, 0, 0);
    chk_err("bad_crc", 8'hA5);
    send_frame(32'h0000_0003, 32'h0000_0005, 3'b011, 8, 4'b0, -1, 0, 0);
    chk_err("bad_op", 8'h93);

    send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 8, 4'b0, -1, 0, 20);
    send_frame(32'h1234_5678, 32'h1111_1111, 3'b100, 8, 4'b0, -1, 0, 0);
    chk_rsp("after_abort", 32'h2345_6789, 4'b0000);

    send_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b001, 8, 4'b0, 3, 1, 0);
    chk_err("bad_stop", 8'hC9);
    send_frame(32'h8000_0000, 32'h0000_0001, 3'b101, 8, 4'b0, -1, 1, 0);
    chk_rsp("sub_ovf_toggle", 32'h7FFF_FFFF, 4'b0100);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: rb = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      ra  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      rop = ops[$urandom_range(0, 7)];
      nd  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : 8;
      cf  = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      bs  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 7) : -1;
      send_frame(rb, ra, rop, nd, cf, bs, 1'($urandom), 0);
    end

    repeat (5) drive_bit(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_responder.md
# alu_serial_responder

Serial-protocol responder for the ALU test environment, sitting at the far end of the `alu_bfm` serial link. It deserializes request frames on `sin` (operand B, operand A, command), checks framing, CRC and opcode, and computes the 32-bit result and flags. It then serializes either a result frame or an error frame on `sout`. The bench uses it as the golden DUT model and as a loopback target for BFM self-checks.

## Interface
- `clk`: input, 1 bit. Single clock; one serial bit per cycle in each direction.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `sin`: input, 1 bit. Serial request line; idles at 1.
- `sout`: output, 1 bit. Serial response line; idles at 1.
- `busy`: output, 1 bit. High from acceptance of a command packet until the last response stop bit.

## Operation
- Packet: 11 bits, MSB first. Fields are start (0), type (0 = data, 1 = ctl), payload[7:0], stop (1).
- Request frame:
  - 8 data packets carrying B[31:24]..B[7:0], then A[31:24]..A[7:0].
  - Then 1 ctl packet with payload {0, OP[2:0], CRC4[3:0]}.
- CRC4:
  - Polynomial x^4+x+1, init 0.
  - Computed MSB first over the 68 bits {B, A, 1'b1, OP}.
- OP encoding: AND=000, OR=001, ADD=100, SUB=101. All other codes are invalid.
- Result C:
  - AND: B&A. OR: B|A. ADD: B+A. SUB: B−A.
  - Arithmetic is 32-bit two's complement.
- Flags[3:0] = {carry, overflow, zero, negative}:
  - carry: ADD carry-out; SUB borrow (B<A unsigned).
  - overflow: signed overflow of ADD/SUB.
  - zero: C==0.
  - negative: C[31].
  - Carry and overflow are 0 for AND/OR.
- Result frame: 4 data packets C[31:24]..C[7:0], then 1 ctl packet with payload {0, FLAGS[3:0], CRC3[2:0]}.
- CRC3: polynomial x^3+x+1, init 0, computed over the 37 bits {C, 1'b0, FLAGS}.
- Error frame: 1 ctl packet with payload {1, E[2:0], E[2:0], P}.
  - E = {err_data, err_crc, err_op}.
  - P makes the 8 payload bits even parity.
  - Exactly one E bit is set, with priority DATA > CRC > OP.
- err_data is raised on any of:
  - a ctl packet arriving after a data count other than 8;
  - a stop bit sampled as 0 in any packet of the frame.
- err_crc: received CRC4 does not match the computed CRC4.
- err_op: OP is invalid.
- Receiver FSM states:
  - RX_IDLE: falling edge of `sin` moves to RX_BITS.
  - RX_BITS: 10 further bits, then RX_EVAL.
  - RX_EVAL: a data packet increments the data count (saturating at 9) and returns to RX_IDLE; a ctl packet moves to RESP.
- Response FSM states:
  - TX_IDLE.
  - TX_DATA: 4 packets.
  - TX_CTL.
  - An error response goes directly to TX_CTL.
  - Packets are sent back-to-back with no idle bits between them.
- While `busy` is high, `sin` is ignored. The receiver restarts in RX_IDLE with the data count at 0 after `busy` falls.

## Timing
- Reset values: `sout`=1, `busy`=0, both FSMs idle, data count 0, shift registers 0.
- `rst` mid-frame or mid-response aborts immediately. `sout` returns to 1 asynchronously; no partial packet is completed.
- A packet's start bit is the first cycle `sin`=0 while in RX_IDLE. The stop bit is sampled 10 cycles later.
- Latency: `busy` rises the cycle after the command packet's stop bit is sampled. The first `sout` start bit follows in the next cycle.
- Response length:
  - Result frame: 55 cycles of `sout` activity.
  - Error frame: 11 cycles.
  - `busy` falls the cycle after the final stop bit.
- The next request start bit is accepted no earlier than the cycle after `busy` falls.

## Test plan
- Request B=0x0000_0003, A=0x0000_0005, OP=ADD, valid CRC4 → C=0x0000_0008, flags 0000, valid CRC3, `busy` high for 56 cycles.
- Request B=0x0000_0001, A=0x0000_0002, OP=SUB → C=0xFFFF_FFFF, flags {1,0,0,1}.
- Request B=0x7FFF_FFFF, A=0x0000_0001, OP=ADD → C=0x8000_0000, flags {0,1,0,1}. A separate request with OP=AND, A=0, B=0xFFFF_FFFF → C=0, flags 0010.
- Send only 7 data packets before the ctl packet → error payload 1_100_100_1 (0xC9). Repeat with a flipped CRC4 bit → 0xA5. Repeat with OP=011 → 0x93.
- Assert `rst` at the 20th response bit → `sout`=1 the same cycle, `busy`=0. A following valid request produces a correct result frame.
- Drive a stop bit of 0 in data packet 3 → error payload 0xC9. Toggling `sin` while `busy` is high has no effect.
